// File: rtl/mem_burst_pkg.sv
// Shared constants and types for the cacheline <-> memory burst adaptor.
package mem_burst_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH  = 32;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int CNT_WIDTH   = $clog2(BEATS);

  // Clears the byte-offset bits so address_o is always line aligned.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} burst_state_t;
  typedef logic [LINE_WIDTH-1:0]  cacheline_t;
  typedef logic [BURST_WIDTH-1:0] beat_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [CNT_WIDTH-1:0]   beat_cnt_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cacheline read/write into a 4-beat 64-bit memory burst.
//
//   state | meaning
//   IDLE  | waiting for read_i/write_i; request sampled each edge
//   READ  | read_o high; each resp_i stores burst_i into the line buffer
//   WRITE | write_o high; burst_o shows current beat, resp_i advances it
//   DONE  | resp_o high for one cycle, then back to IDLE
module cacheline_adaptor
  import mem_burst_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  cacheline_t  line_i,
  output cacheline_t  line_o,
  input  addr_t       address_i,
  input  logic        read_i,
  input  logic        write_i,
  output logic        resp_o,
  input  beat_t       burst_i,
  output beat_t       burst_o,
  output addr_t       address_o,
  output logic        read_o,
  output logic        write_o,
  input  logic        resp_i
);

  burst_state_t state_q, state_d;
  beat_cnt_t    cnt_q,   cnt_d;
  addr_t        addr_q,  addr_d;
  cacheline_t   line_q,  line_d;
  cacheline_t   rline_q, rline_d;

  logic last_beat;
  assign last_beat = resp_i && (cnt_q == CNT_WIDTH'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    rline_d = rline_q;
    unique case (state_q)
      IDLE: begin
        if (read_i) begin
          addr_d  = address_i & ADDR_MASK;
          cnt_d   = '0;
          state_d = READ;
        end else if (write_i) begin
          addr_d  = address_i & ADDR_MASK;
          line_d  = line_i;
          cnt_d   = '0;
          state_d = WRITE;
        end
      end
      READ: begin
        if (resp_i) begin
          line_d[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH] = burst_i;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (last_beat) begin
            // line_o gets its own copy so a later write cannot disturb it
            rline_d = line_d;
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        if (resp_i) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (last_beat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      rline_q <= rline_d;
    end
  end

  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign address_o = addr_q;
  assign line_o    = rline_q;
  assign burst_o   = (state_q == WRITE) ? line_q[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH] : '0;

endmodule
